eq_band_scheduler: RTL and testbench
====================================

Name: eq_band_scheduler

Overview:
Sequences one shared band-filter unit across all EQ bands for each incoming ADC sample. It issues one request per band, then weights each band response by that band's stored gain. It accumulates the weighted results, applies the global offset attenuation, and emits one saturated output sample with a done pulse to the DAC path. It sits between the ADC controller (doneR/data) and the DAC controller (valid/data), replacing per-band parallel multipliers.

Parameters:
NBAND, 6, highest band index; bands 0..NBAND (NBAND+1 bands)
DW, 16, sample / response width (signed)
GAIN_ONE, 16, unity weight; band weight = GAIN_ONE + gain

Ports:
i_clk  input  1  BCLK domain clock
i_rst  input  1  asynchronous active-high reset
i_sample_valid  input  1  one-cycle strobe: new ADC sample
i_sample  input  DW  signed ADC sample
i_offset  input  3  global attenuation shift; values >3 treated as 3
i_gain_we  input  1  gain table write enable
i_gain_band  input  3  band index for write
i_gain_val  input  16  signed gain value for write
i_clear  input  1  synchronous clear: gains to 0, abort sample
o_req  output  1  request to shared filter unit
o_band  output  3  band index of request
o_req_data  output  DW  sample sent with request
i_ack  input  1  filter unit accepted request
i_resp_valid  input  1  one-cycle strobe: band response ready
i_resp_data  input  DW  signed band response
o_data  output  DW  processed sample to DAC
o_done  output  1  one-cycle strobe: o_data valid
o_busy  output  1  high in any state but IDLE
o_overrun  output  8  saturating count of dropped samples

Behaviour:
- Reset (async): state IDLE, band 0, acc 0, gain table all 0. Outputs o_req=0, o_band=0, o_req_data=0, o_data=0, o_done=0, o_busy=0, o_overrun=0.
- States: IDLE, ISSUE, WAIT, ACCUM, OUTPUT.
- IDLE: on i_sample_valid, latch i_sample, set band=0 and acc=0, go to ISSUE.
- ISSUE: o_req=1, o_band=band, o_req_data=latched sample. All three stay stable until i_ack. On i_ack, go to WAIT; o_req falls the next cycle.
- WAIT: on i_resp_valid, capture i_resp_data and go to ACCUM. A response arriving in the ack cycle is ignored; the filter unit must respond at least 1 cycle after ack.
- ACCUM: acc += (resp * (GAIN_ONE + gain[band])) >>> 4, using signed arithmetic and a 24-bit acc. If band==NBAND, go to OUTPUT; else band+1 and go to ISSUE.
- OUTPUT: o_data <= saturate_DW(acc >>> min(i_offset,3)); o_done=1 for exactly one cycle; go to IDLE.
- Minimum latency with ack in the first ISSUE cycle and resp the next cycle: 3 cycles per band, plus 1 for OUTPUT. That is 3*(NBAND+1)+1 = 22 cycles from the first ISSUE cycle to the o_done cycle.
- Saturation: clamp to [-2^(DW-1), 2^(DW-1)-1].
- Gain writes:
  - Accepted in any state.
  - i_gain_val is clamped to [-12, +12] before storing.
  - i_gain_band > NBAND: write ignored.
  - A write lands at the clock edge; an ACCUM of that band in the same cycle uses the old value.
- Overrun: i_sample_valid in any state but IDLE drops that sample. o_overrun increments and saturates at 255. The in-flight sample is unaffected.
- i_clear:
  - Zeroes the gain table.
  - Returns to IDLE next cycle: o_req=0, no o_done for the aborted sample, acc=0.
  - o_data holds its last value; o_overrun is not cleared.
  - If i_clear and i_sample_valid arrive in the same cycle, i_clear wins and the sample is dropped without counting.
  - If i_clear and i_gain_we arrive in the same cycle, i_clear wins.
- Mid-operation reset: o_req drops immediately (async). A later stray i_resp_valid in IDLE is ignored.

Test Plan:
1. All gains 0, offset 0; filter model acks immediately and returns 1000 for every band. Required: o_data=7000, o_done exactly 22 cycles after the first o_req, o_band stepping 0..6.
2. Write band 3 gain=+40, which clamps to +12. Same stimulus as scenario 1. Required: band 3 contributes 1750, so o_data=7750. With offset 2: o_data=1937.
3. Responses of -1000 on all bands, all gains -12. Required: each band -250, so o_data=-1750. Then responses of 32767 with all gains +12. Required: o_data=32767, saturated.
4. Filter model delays ack by 5 cycles and response by 3. Required: o_req, o_band and o_req_data stay stable until ack. Second i_sample_valid during WAIT: o_overrun=1, only one o_done produced.
5. Assert i_clear during band-4 WAIT. Required: o_req=0 and state IDLE next cycle, no o_done, all gains read back 0. The next sample with responses of 1000 gives o_data=7000.
6. Assert i_rst during ISSUE. Required: o_req=0 immediately with all outputs at reset values. A later i_resp_valid is ignored, and the next sample completes normally.

Source files
------------

// File: rtl/eq_band_if.sv
// Bus bundle between the EQ band scheduler, the ADC/DAC paths and the shared band-filter unit.
interface eq_band_if #(
    parameter int DW = 16
);
    logic                 i_sample_valid;
    logic signed [DW-1:0] i_sample;
    logic [2:0]           i_offset;
    logic                 i_gain_we;
    logic [2:0]           i_gain_band;
    logic signed [15:0]   i_gain_val;
    logic                 i_clear;
    logic                 o_req;
    logic [2:0]           o_band;
    logic signed [DW-1:0] o_req_data;
    logic                 i_ack;
    logic                 i_resp_valid;
    logic signed [DW-1:0] i_resp_data;
    logic signed [DW-1:0] o_data;
    logic                 o_done;
    logic                 o_busy;
    logic [7:0]           o_overrun;

    modport slave (
        input  i_sample_valid, i_sample, i_offset, i_gain_we, i_gain_band, i_gain_val,
        input  i_clear, i_ack, i_resp_valid, i_resp_data,
        output o_req, o_band, o_req_data, o_data, o_done, o_busy, o_overrun
    );

    modport master (
        output i_sample_valid, i_sample, i_offset, i_gain_we, i_gain_band, i_gain_val,
        output i_clear, i_ack, i_resp_valid, i_resp_data,
        input  o_req, o_band, o_req_data, o_data, o_done, o_busy, o_overrun
    );
endinterface

// File: rtl/eq_band_scheduler.sv
// Time-multiplexes one band-filter unit over all EQ bands per ADC sample, weighting each
// band response by its stored gain and emitting one attenuated, saturated sample.
module eq_band_scheduler #(
    parameter int NBAND    = 6,
    parameter int DW       = 16,
    parameter int GAIN_ONE = 16
) (
    input  logic      i_clk,
    input  logic      i_rst,
    eq_band_if.slave  bus
);
    localparam int AW = 24;
    localparam logic signed [AW-1:0] SAT_HI = AW'((64'sd1 <<< (DW-1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACCUM, S_OUTPUT} state_t;

    state_t               r_state;
    logic [2:0]           r_band;
    logic signed [DW-1:0] r_resp;
    logic signed [AW-1:0] r_acc;
    logic                 r_req;
    logic signed [DW-1:0] r_req_data;
    logic signed [DW-1:0] r_data;
    logic                 r_done;
    logic                 r_busy;
    logic [7:0]           r_overrun;
    logic signed [4:0]    r_gain [0:NBAND];

    logic signed [4:0]    w_gain;
    logic signed [AW-1:0] w_resp_ext;
    logic signed [AW-1:0] w_weight;
    logic signed [AW-1:0] w_term;
    logic signed [AW-1:0] w_shifted;
    logic [1:0]           w_shift;

    function automatic logic signed [4:0] clamp_gain(input logic signed [15:0] v);
        if (v > 16'sd12)       clamp_gain = 5'sd12;
        else if (v < -16'sd12) clamp_gain = -5'sd12;
        else                   clamp_gain = v[4:0];
    endfunction

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
        if (v > SAT_HI)      sat_dw = SAT_HI[DW-1:0];
        else if (v < SAT_LO) sat_dw = SAT_LO[DW-1:0];
        else                 sat_dw = v[DW-1:0];
    endfunction

    // Weighted contribution of the captured response; a gain write in the same cycle lands after this read.
    assign w_gain     = r_gain[r_band];
    assign w_resp_ext = {{(AW-DW){r_resp[DW-1]}}, r_resp};
    assign w_weight   = AW'(GAIN_ONE) + {{(AW-5){w_gain[4]}}, w_gain};
    assign w_term     = (w_resp_ext * w_weight) >>> 3'd4;
    assign w_shift    = (bus.i_offset > 3'd3) ? 2'd3 : bus.i_offset[1:0];
    assign w_shifted  = r_acc >>> w_shift;

    // Band sequencing FSM with registered request/output signals.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_band     <= 3'd0;
            r_resp     <= '0;
            r_acc      <= '0;
            r_req      <= 1'b0;
            r_req_data <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else if (bus.i_clear) begin
            r_state <= S_IDLE;
            r_band  <= 3'd0;
            r_acc   <= '0;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_sample_valid) begin
                        r_req_data <= bus.i_sample;
                        r_band     <= 3'd0;
                        r_acc      <= '0;
                        r_req      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.i_ack) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.i_resp_valid) begin
                        r_resp  <= bus.i_resp_data;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_acc <= r_acc + w_term;
                    if (r_band == 3'(NBAND)) begin
                        r_state <= S_OUTPUT;
                    end else begin
                        r_band  <= r_band + 3'd1;
                        r_req   <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_OUTPUT: begin
                    r_data  <= sat_dw(w_shifted);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Gain table writes and dropped-sample counter; clear overrides a simultaneous write or sample.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b <= NBAND; b++) r_gain[b] <= 5'sd0;
            r_overrun <= 8'd0;
        end else begin
            if (bus.i_clear) begin
                for (int b = 0; b <= NBAND; b++) r_gain[b] <= 5'sd0;
            end else if (bus.i_gain_we && (bus.i_gain_band <= 3'(NBAND))) begin
                r_gain[bus.i_gain_band] <= clamp_gain(bus.i_gain_val);
            end
            if (!bus.i_clear && bus.i_sample_valid && (r_state != S_IDLE) && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 8'd1;
            end
        end
    end

    assign bus.o_req      = r_req;
    assign bus.o_band     = r_band;
    assign bus.o_req_data = r_req_data;
    assign bus.o_data     = r_data;
    assign bus.o_done     = r_done;
    assign bus.o_busy     = r_busy;
    assign bus.o_overrun  = r_overrun;
endmodule

// File: tb/tb_eq_band_scheduler.sv
// Self-checking bench for eq_band_scheduler: vector table, hand-built corner sequences and
// randomized samples against an arithmetic reference of the weighted band sum.
module tb_eq_band_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eq_band_if #(.DW(16)) bus();

    eq_band_scheduler #(.NBAND(6), .DW(16), .GAIN_ONE(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int band_w;
        int gain_w;
        int resp;
        int off;
        int exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int sg [0:6];
    int ov_exp = 0;
    int exp_last = 0;

    int fm_ack_dly = 0;
    int fm_resp_dly = 1;
    int stray_req = 0;
    logic signed [15:0] fm_resp [0:7];

    int rs_data, rs_lat, rs_nreq;
    bit rs_done, rs_seq_ok, rs_stable_ok;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input longint v, input longint lo, input longint hi);
        if (v < lo) return int'(lo);
        if (v > hi) return int'(hi);
        return int'(v);
    endfunction

    // Expected output: sum of floor(resp*(16+gain)/16) over bands, attenuated, saturated.
    function automatic int ref_out(input int off);
        longint acc;
        int sh;
        acc = 0;
        for (int b = 0; b < 7; b++)
            acc += (longint'(fm_resp[b]) * longint'(16 + sg[b])) >>> 4;
        sh = (off > 3) ? 3 : off;
        acc = acc >>> sh;
        return clampi(acc, -32768, 32767);
    endfunction

    task automatic set_resp(input int v);
        for (int b = 0; b < 8; b++) fm_resp[b] = 16'(v);
    endtask

    task automatic write_gain(input int band, input int val);
        @(negedge clk);
        bus.i_gain_we   = 1'b1;
        bus.i_gain_band = 3'(band);
        bus.i_gain_val  = 16'(val);
        @(negedge clk);
        bus.i_gain_we = 1'b0;
        if (band <= 6) sg[band] = clampi(val, -12, 12);
    endtask

    task automatic run_sample(input int s, input int off, input bit inject);
        bit injected;
        bit prev;
        logic [2:0] band_v;
        logic [15:0] data_v;
        injected = 1'b0; prev = 1'b0; band_v = 3'd0; data_v = 16'd0;
        rs_done = 1'b0; rs_nreq = 0; rs_seq_ok = 1'b1; rs_stable_ok = 1'b1; rs_lat = -1; rs_data = 0;
        @(negedge clk);
        bus.i_sample = 16'(s);
        bus.i_offset = 3'(off);
        bus.i_sample_valid = 1'b1;
        @(negedge clk);
        bus.i_sample_valid = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bus.i_sample_valid = 1'b0;
            if (bus.o_done) begin
                rs_done = 1'b1; rs_lat = cyc; rs_data = int'(bus.o_data);
                break;
            end
            if (bus.o_req && !prev) begin
                if (int'(bus.o_band) != rs_nreq || bus.o_req_data != 16'(s)) rs_seq_ok = 1'b0;
                rs_nreq++;
                band_v = bus.o_band;
                data_v = bus.o_req_data;
            end else if (bus.o_req && prev) begin
                if (bus.o_band != band_v || bus.o_req_data != data_v) rs_stable_ok = 1'b0;
            end
            if (inject && !injected && !bus.o_req && bus.o_busy) begin
                bus.i_sample = 16'h5555;
                bus.i_sample_valid = 1'b1;
                injected = 1'b1;
            end
            prev = bus.o_req;
            @(negedge clk);
        end
        bus.i_sample_valid = 1'b0;
        chk("done_seen", int'(rs_done), 1);
        if (rs_done) begin
            @(negedge clk);
            chk("done_one_cycle", int'(bus.o_done), 0);
        end
    endtask

    // Shared band-filter model: ack after fm_ack_dly cycles, respond fm_resp_dly cycles after ack.
    initial begin : filter_model
        int ack_cnt;
        int resp_cnt;
        bit pending;
        logic [2:0] pb;
        int stray_done;
        ack_cnt = 0; resp_cnt = 0; pending = 1'b0; pb = 3'd0; stray_done = 0;
        bus.i_ack = 1'b0; bus.i_resp_valid = 1'b0; bus.i_resp_data = 16'sd0;
        forever begin
            @(negedge clk);
            bus.i_ack = 1'b0;
            bus.i_resp_valid = 1'b0;
            if (rst) begin
                pending = 1'b0; ack_cnt = 0;
            end else if (stray_req != stray_done) begin
                stray_done = stray_req;
                bus.i_resp_valid = 1'b1;
                bus.i_resp_data = 16'sd1234;
            end else if (pending) begin
                if (resp_cnt <= 0) begin
                    bus.i_resp_valid = 1'b1;
                    bus.i_resp_data = fm_resp[pb];
                    pending = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end else if (bus.o_req) begin
                if (ack_cnt >= fm_ack_dly) begin
                    bus.i_ack = 1'b1; ack_cnt = 0; pending = 1'b1;
                    resp_cnt = fm_resp_dly - 1; pb = bus.o_band;
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    initial begin : main
        vec_t tab [4];
        int exp_v;
        int nd;
        int off;
        bit hit;
        tab[0] = '{0, 0, 1000, 0, 7000};
        tab[1] = '{3, 40, 1000, 0, 7750};
        tab[2] = '{7, 12, 1000, 2, 1937};
        tab[3] = '{3, 0, 1000, 7, 875};

        for (int b = 0; b < 7; b++) sg[b] = 0;
        set_resp(1000);
        rst = 1'b1;
        bus.i_sample_valid = 1'b0; bus.i_sample = 16'sd0; bus.i_offset = 3'd0;
        bus.i_gain_we = 1'b0; bus.i_gain_band = 3'd0; bus.i_gain_val = 16'sd0; bus.i_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", int'(bus.o_req), 0);
        chk("rst_band", int'(bus.o_band), 0);
        chk("rst_req_data", int'(bus.o_req_data), 0);
        chk("rst_data", int'(bus.o_data), 0);
        chk("rst_done", int'(bus.o_done), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_overrun", int'(bus.o_overrun), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table: unity gains, clamped gain, ignored out-of-range band, offset clamp.
        for (int i = 0; i < 4; i++) begin
            write_gain(tab[i].band_w, tab[i].gain_w);
            set_resp(tab[i].resp);
            run_sample(100 + i, tab[i].off, 1'b0);
            chk($sformatf("vec%0d_data", i), rs_data, tab[i].exp);
            exp_last = tab[i].exp;
            if (i == 0) begin
                chk("latency", rs_lat, 22);
                chk("band_count", rs_nreq, 7);
                chk("band_sequence", int'(rs_seq_ok), 1);
            end
        end

        // Minimum gains with negative responses, then positive saturation and negative saturation.
        for (int b = 0; b < 7; b++) write_gain(b, -12);
        set_resp(-1000);
        run_sample(-5, 0, 1'b0);
        chk("neg_gain_data", rs_data, -1750);
        for (int b = 0; b < 7; b++) write_gain(b, 12);
        set_resp(32767);
        run_sample(7, 0, 1'b0);
        chk("sat_pos", rs_data, 32767);
        set_resp(-32768);
        run_sample(8, 0, 1'b0);
        chk("sat_neg", rs_data, -32768);
        exp_last = -32768;
        for (int b = 0; b < 7; b++) write_gain(b, 0);

        // Slow filter: request held stable until ack, sample dropped during WAIT.
        fm_ack_dly = 5; fm_resp_dly = 3;
        set_resp(1000);
        run_sample(321, 0, 1'b1);
        ov_exp = 1;
        chk("slow_data", rs_data, 7000);
        chk("slow_req_stable", int'(rs_stable_ok), 1);
        chk("slow_band_sequence", int'(rs_seq_ok), 1);
        chk("overrun_one", int'(bus.o_overrun), ov_exp);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_done) nd++;
        end
        chk("dropped_no_done", nd, 0);
        exp_last = 7000;

        // Randomized gains, responses, offsets and filter timing.
        for (int it = 0; it < 24; it++) begin
            fm_ack_dly = $urandom_range(0, 3);
            fm_resp_dly = $urandom_range(1, 3);
            write_gain($urandom_range(0, 7), int'($urandom_range(0, 60)) - 30);
            write_gain($urandom_range(0, 7), int'($urandom_range(0, 60)) - 30);
            for (int b = 0; b < 8; b++) fm_resp[b] = 16'($urandom);
            if (it % 4 == 3) begin
                for (int b = 0; b < 8; b++) fm_resp[b] = (it % 8 == 3) ? 16'sh7FFF : 16'sh8000;
            end
            off = $urandom_range(0, 7);
            exp_v = ref_out(off);
            run_sample($urandom_range(0, 65535), off, 1'b0);
            chk($sformatf("rand%0d_data", it), rs_data, exp_v);
            exp_last = exp_v;
        end

        // Clear during band-4 WAIT, with a simultaneous gain write that must lose.
        for (int b = 0; b < 7; b++) write_gain(b, 12);
        fm_ack_dly = 0; fm_resp_dly = 3;
        set_resp(1000);
        @(negedge clk);
        bus.i_sample = 16'sd99; bus.i_offset = 3'd0; bus.i_sample_valid = 1'b1;
        @(negedge clk);
        bus.i_sample_valid = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (bus.o_band == 3'd4 && !bus.o_req && bus.o_busy) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("clear_reach_band4", int'(hit), 1);
        bus.i_clear = 1'b1;
        bus.i_gain_we = 1'b1; bus.i_gain_band = 3'd0; bus.i_gain_val = 16'sd12;
        @(negedge clk);
        bus.i_clear = 1'b0; bus.i_gain_we = 1'b0;
        for (int b = 0; b < 7; b++) sg[b] = 0;
        chk("clear_req", int'(bus.o_req), 0);
        chk("clear_busy", int'(bus.o_busy), 0);
        chk("clear_data_held", int'(bus.o_data), exp_last);
        chk("clear_overrun_kept", int'(bus.o_overrun), ov_exp);
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.o_done) nd++;
        end
        chk("clear_no_done", nd, 0);
        bus.i_clear = 1'b1; bus.i_sample_valid = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0; bus.i_sample_valid = 1'b0;
        @(negedge clk);
        chk("clear_wins_busy", int'(bus.o_busy), 0);
        chk("clear_wins_overrun", int'(bus.o_overrun), ov_exp);
        fm_resp_dly = 1;
        run_sample(55, 0, 1'b0);
        chk("after_clear_data", rs_data, 7000);

        // Overrun counter saturates at 255 while a sample is stalled in ISSUE.
        fm_ack_dly = 1000;
        @(negedge clk);
        bus.i_sample = 16'sd100; bus.i_sample_valid = 1'b1;
        repeat (261) @(negedge clk);
        bus.i_sample_valid = 1'b0;
        ov_exp = 255;
        chk("overrun_sat", int'(bus.o_overrun), ov_exp);
        fm_ack_dly = 0;
        hit = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.o_done) begin
                hit = 1'b1;
                break;
            end
        end
        chk("stalled_done", int'(hit), 1);
        chk("stalled_data", int'(bus.o_data), ref_out(0));

        // Async reset while in ISSUE, stray response afterwards, then a normal sample.
        fm_ack_dly = 50;
        @(negedge clk);
        bus.i_sample = 16'sd77; bus.i_sample_valid = 1'b1;
        @(negedge clk);
        bus.i_sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("issue_before_rst", int'(bus.o_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", int'(bus.o_req), 0);
        chk("arst_band", int'(bus.o_band), 0);
        chk("arst_req_data", int'(bus.o_req_data), 0);
        chk("arst_data", int'(bus.o_data), 0);
        chk("arst_busy", int'(bus.o_busy), 0);
        chk("arst_overrun", int'(bus.o_overrun), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < 7; b++) sg[b] = 0;
        ov_exp = 0;
        stray_req++;
        repeat (4) @(negedge clk);
        chk("stray_busy", int'(bus.o_busy), 0);
        chk("stray_done", int'(bus.o_done), 0);
        fm_ack_dly = 0;
        run_sample(1, 0, 1'b0);
        chk("after_rst_data", rs_data, 7000);
        chk("after_rst_overrun", int'(bus.o_overrun), ov_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
